aes_round_sequencer: RTL

Sequences one AES-128 encryption over the shared round datapath and the key schedule block. After a start request it loads state and key, runs the initial AddRoundKey, then runs rounds 1..NR. Each round is SubBytes, ShiftRows, MixColumns (skipped in the final round) and AddRoundKey. It requests each next round key from the key schedule and presents the result through a valid/ready handshake.

---
 rtl/aes_round_sequencer_if.sv | 31 +++
 rtl/aes_round_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer_if.sv
// Control bundle between the AES round sequencer, its stimulus/consumer side,
// the key schedule and the round datapath.
`timescale 1ns/1ps
interface aes_round_sequencer_if;
    logic       start;
    logic       key_valid;
    logic       out_ready;
    logic       busy;
    logic       ld_state;
    logic       key_load;
    logic       key_req;
    logic       do_sub;
    logic       do_shift;
    logic       do_mix;
    logic       do_ark;
    logic [3:0] rnd;
    logic       out_valid;
    logic       err;

    modport slave (
        input  start, key_valid, out_ready,
        output busy, ld_state, key_load, key_req, do_sub, do_shift, do_mix,
               do_ark, rnd, out_valid, err
    );

    modport master (
        output start, key_valid, out_ready,
        input  busy, ld_state, key_load, key_req, do_sub, do_shift, do_mix,
               do_ark, rnd, out_valid, err
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Sequences one AES-128 encryption: load, initial AddRoundKey, then NR rounds
// of SubBytes/ShiftRows/MixColumns/AddRoundKey with key-schedule handshaking.
`timescale 1ns/1ps
module aes_round_sequencer #(
    parameter int NR      = 10,
    parameter int SUB_LAT = 1,
    parameter int KEY_TO  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_round_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARK0, S_SUB, S_SHIFT, S_MIX, S_ARK, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic [1:0] sub_cnt_q, sub_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       key_pending_q, key_pending_d;
    logic       err_q, err_d;

    logic ld_state, key_load, key_req, do_sub, do_shift, do_mix, do_ark;
    logic out_valid, ark_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rnd_q         <= '0;
            sub_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            key_pending_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rnd_q         <= rnd_d;
            sub_cnt_q     <= sub_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            key_pending_q <= key_pending_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rnd_d         = rnd_q;
        sub_cnt_d     = sub_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        key_pending_d = key_pending_q;
        err_d         = err_q;
        ld_state      = 1'b0;
        key_load      = 1'b0;
        key_req       = 1'b0;
        do_sub        = 1'b0;
        do_shift      = 1'b0;
        do_mix        = 1'b0;
        do_ark        = 1'b0;
        out_valid     = 1'b0;
        ark_ok        = 1'b0;

        // A key_valid seen in the request cycle itself belongs to the old key.
        if (key_pending_q && bus.key_valid) key_pending_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                ld_state      = 1'b1;
                key_load      = 1'b1;
                rnd_d         = '0;
                sub_cnt_d     = '0;
                wait_cnt_d    = '0;
                key_pending_d = 1'b0;
                state_d       = S_ARK0;
            end
            S_ARK0, S_ARK: begin
                ark_ok = bus.key_valid && ((state_q == S_ARK0) || !key_pending_q);
                if (ark_ok) begin
                    do_ark     = 1'b1;
                    wait_cnt_d = '0;
                    if (state_q == S_ARK0) begin
                        rnd_d   = 4'd1;
                        state_d = S_SUB;
                    end else if (rnd_q == 4'(NR)) begin
                        state_d = S_DONE;
                    end else begin
                        rnd_d   = rnd_q + 4'd1;
                        state_d = S_SUB;
                    end
                end else if (wait_cnt_q == 8'(KEY_TO - 1)) begin
                    err_d      = 1'b1;
                    rnd_d      = '0;
                    wait_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_SUB: begin
                do_sub = 1'b1;
                if (sub_cnt_q == 2'd0) begin
                    key_req       = 1'b1;
                    key_pending_d = 1'b1;
                end
                if (sub_cnt_q == 2'(SUB_LAT - 1)) begin
                    sub_cnt_d = '0;
                    state_d   = S_SHIFT;
                end else begin
                    sub_cnt_d = sub_cnt_q + 2'd1;
                end
            end
            S_SHIFT: begin
                do_shift = 1'b1;
                state_d  = (rnd_q < 4'(NR)) ? S_MIX : S_ARK;
            end
            S_MIX: begin
                do_mix  = 1'b1;
                state_d = S_ARK;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ld_state  = ld_state;
    assign bus.key_load  = key_load;
    assign bus.key_req   = key_req;
    assign bus.do_sub    = do_sub;
    assign bus.do_shift  = do_shift;
    assign bus.do_mix    = do_mix;
    assign bus.do_ark    = do_ark;
    assign bus.rnd       = rnd_q;
    assign bus.out_valid = out_valid;
    assign bus.err       = err_q;

endmodule
